fp_fcl_seq: RTL and testbench
=============================

# fp_fcl_seq

Sequencer for the fixed-point fully-connected array `fp_fcl`.
- Walks one input vector of `in_len` elements across `num_tiles` output tiles of `FP_PARALLEL` neurons each.
- Issues input and weight memory reads and drives the array's accumulate-clear (`rst` pin) and `shift`.
- Captures the array outputs into a valid/ready output register.
- Sits between the layer-level control FSM, the input/weight SRAMs (which feed `fp_fcl` directly) and the downstream activation buffer.

## Interface
Parameters:
- FP_WIDTH, 16, lane width
- FP_PARALLEL, 8, lanes per tile
- LEN_W, 10, width of `in_len`
- TILE_W, 8, width of `num_tiles`
- WADDR_W, 18, weight address width
- SHIFT_W, 6, `shift` width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  start pulse; sampled in IDLE only
- in_len  in  LEN_W  elements per tile; latched at start
- num_tiles  in  TILE_W  tiles per layer; latched at start
- shift_cfg  in  SHIFT_W  latched at start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse
- in_rd  out  1  input SRAM read strobe
- in_addr  out  LEN_W  input element index
- w_rd  out  1  weight SRAM read strobe
- w_addr  out  WADDR_W  weight word address
- pe_rst_n  out  1  to `fp_fcl.rst`; low = load product, high = accumulate
- pe_shift  out  SHIFT_W  to `fp_fcl.shift`
- pe_out  in  FP_PARALLEL*FP_WIDTH  `fp_fcl.OUTPUT`
- out_valid  out  1  output register full
- out_ready  in  1  downstream accept
- out_data  out  FP_PARALLEL*FP_WIDTH  captured tile
- out_tile  out  TILE_W  tile index of out_data

## Operation
- FSM states: IDLE, RUN, WAIT, CAPT, NEXT.
- IDLE:
  - `start` with `in_len`≠0 and `num_tiles`≠0: latch config, tile=0, busy=1, go to RUN.
  - `start` with either field zero: no reads, no output, `done` pulses next cycle, stay IDLE.
  - `start` outside IDLE is ignored.
- RUN (L=in_len cycles, j=0..L-1):
  - in_rd=w_rd=1, in_addr=j, w_addr=tile*L+j.
  - The multiply for w_addr uses a running base register: base+=L per tile; no multiplier.
- SRAM read latency is 1 cycle; data for element j reaches the array in cycle RUN_j+1.
  - pe_rst_n=0 in exactly the cycle element 0's data is presented; 1 in the cycles for elements 1..L-1.
  - L=1: the single data cycle is the load cycle.
- WAIT (1 cycle): last element presented; reads deasserted.
- CAPT (1 cycle): out_data←pe_out, out_tile←tile, out_valid←1.
  - Last tile: go to IDLE, busy←0, done pulses the following cycle.
  - Otherwise: tile+1, go to NEXT.
- NEXT: go to RUN when !out_valid || out_ready; else hold. This entry rule guarantees the output register is free at every CAPT; no capture is ever dropped.
- Output register: cleared on out_valid&&out_ready unless a CAPT loads it in the same cycle. A load wins.
- pe_shift = latched shift_cfg whenever busy; 0 in IDLE.

## Timing
- Reset values: busy=0, done=0, in_rd=w_rd=0, in_addr=w_addr=0, pe_rst_n=0, pe_shift=0, out_valid=0, out_data=0, out_tile=0; FSM=IDLE.
- start accepted in cycle S → first RUN cycle S+1 → CAPT at S+L+2 → out_valid high from S+L+3.
- Tile period with immediate acceptance: L+3 cycles.
- done asserts in the cycle after the last CAPT. out_valid may still be high.
- Reset mid-operation: abort next edge, all state to reset values, no done, pending output discarded.

## Configuration
- FCL_RELU_EN defined: each FP_WIDTH lane of pe_out with its sign bit set is captured as 0.
- FCL_RELU_EN undefined: pe_out is captured unchanged.

## Test plan
- in_len=4, num_tiles=1, shift_cfg=0, out_ready=1:
  - w_addr 0..3 in cycles S+1..S+4; pe_rst_n=0 only at S+2.
  - out_valid at S+7, out_tile=0; done at S+7.
- in_len=3, num_tiles=3, out_ready=1: w_addr sequences 0-2, 3-5, 6-8; out_tile 0,1,2 with period 6 cycles; single done.
- Same run with out_ready=0 for 20 cycles after first capture: NEXT holds, no reads; tile 1 starts the cycle out_ready rises; no output lost.
- in_len=0 or num_tiles=0: no in_rd/w_rd, out_valid stays 0, done pulse at S+1.
- rst low during RUN of tile 1 of 3: next cycle all outputs at reset values, no done; a new start then runs cleanly from tile 0.
- FCL_RELU_EN, lane values {-5,7}: out_data lanes {0,7}; without macro {-5,7}.

Source files
------------

// File: rtl/fp_fcl_seq.sv
// rtl/fp_fcl_seq.sv - input/weight read sequencer and output capture for fp_fcl (optional FCL_RELU_EN)
module fp_fcl_seq #(
  parameter int FP_WIDTH    = 16,
  parameter int FP_PARALLEL = 8,
  parameter int LEN_W       = 10,
  parameter int TILE_W      = 8,
  parameter int WADDR_W     = 18,
  parameter int SHIFT_W     = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_W-1:0]                in_len,
  input  logic [TILE_W-1:0]               num_tiles,
  input  logic [SHIFT_W-1:0]              shift_cfg,
  output logic                            busy,
  output logic                            done,
  output logic                            in_rd,
  output logic [LEN_W-1:0]                in_addr,
  output logic                            w_rd,
  output logic [WADDR_W-1:0]              w_addr,
  output logic                            pe_rst_n,
  output logic [SHIFT_W-1:0]              pe_shift,
  input  logic [FP_PARALLEL*FP_WIDTH-1:0] pe_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FP_PARALLEL*FP_WIDTH-1:0] out_data,
  output logic [TILE_W-1:0]               out_tile
);

  localparam int OUT_W = FP_PARALLEL * FP_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;
  localparam logic [TILE_W-1:0] TILE_ONE = 1;

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TILE_W-1:0]  tiles_q, tiles_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [LEN_W-1:0]   j_q, j_d;
  logic [WADDR_W-1:0] base_q, base_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load_q, load_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [TILE_W-1:0]  out_tile_q, out_tile_d;
  logic [OUT_W-1:0]   capt_data;

  always_comb begin
    capt_data = pe_out;
`ifdef FCL_RELU_EN
    for (int i = 0; i < FP_PARALLEL; i++) begin
      if (pe_out[i*FP_WIDTH + FP_WIDTH - 1]) begin
        capt_data[i*FP_WIDTH +: FP_WIDTH] = '0;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    tiles_d     = tiles_q;
    shift_d     = shift_q;
    tile_d      = tile_q;
    j_d         = j_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // Element 0 is presented to the array the cycle after its read is issued.
    load_d      = (state_q == S_RUN) && (j_q == '0);
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_tile_d  = out_tile_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((in_len != '0) && (num_tiles != '0)) begin
            len_d   = in_len;
            tiles_d = num_tiles;
            shift_d = shift_cfg;
            tile_d  = '0;
            j_d     = '0;
            base_d  = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (j_q == len_q - LEN_ONE) begin
          j_d     = '0;
          state_d = S_WAIT;
        end else begin
          j_d = j_q + LEN_ONE;
        end
      end
      S_WAIT: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        out_valid_d = 1'b1;
        out_data_d  = capt_data;
        out_tile_d  = tile_q;
        if (tile_q == tiles_q - TILE_ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tile_d  = tile_q + TILE_ONE;
          base_d  = base_q + WADDR_W'(len_q);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Only restart once the output register will be free by the next capture.
        if (!out_valid_q || out_ready) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      tiles_q     <= '0;
      shift_q     <= '0;
      tile_q      <= '0;
      j_q         <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tile_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tiles_q     <= tiles_d;
      shift_q     <= shift_d;
      tile_q      <= tile_d;
      j_q         <= j_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_q      <= load_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tile_q  <= out_tile_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_rd     = (state_q == S_RUN);
  assign w_rd      = (state_q == S_RUN);
  assign in_addr   = in_rd ? j_q : '0;
  assign w_addr    = in_rd ? (base_q + WADDR_W'(j_q)) : '0;
  assign pe_rst_n  = busy_q && !load_q;
  assign pe_shift  = busy_q ? shift_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tile  = out_tile_q;

endmodule

// File: tb/tb_fp_fcl_seq.sv
// tb/tb_fp_fcl_seq.sv - randomized bench for fp_fcl_seq with an fp_fcl array and SRAM model (honours FCL_RELU_EN)
module tb_fp_fcl_seq;
  localparam int W  = 16;
  localparam int P  = 8;
  localparam int LW = 10;
  localparam int TW = 8;
  localparam int AW = 18;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] in_len = '0;
  logic [TW-1:0] num_tiles = '0;
  logic [SW-1:0] shift_cfg = '0;
  logic          busy, done, in_rd, w_rd, pe_rst_n, out_valid;
  logic [LW-1:0] in_addr;
  logic [AW-1:0] w_addr;
  logic [SW-1:0] pe_shift;
  logic [P*W-1:0] pe_out = '0;
  logic          out_ready = 1'b1;
  logic [P*W-1:0] out_data;
  logic [TW-1:0] out_tile;

  fp_fcl_seq dut (
    .clk(clk), .rst(rst), .start(start), .in_len(in_len), .num_tiles(num_tiles),
    .shift_cfg(shift_cfg), .busy(busy), .done(done), .in_rd(in_rd), .in_addr(in_addr),
    .w_rd(w_rd), .w_addr(w_addr), .pe_rst_n(pe_rst_n), .pe_shift(pe_shift),
    .pe_out(pe_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tile(out_tile)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0]   xmem [0:1023];
  logic [P*W-1:0] wmem [0:255];
  int             exp_in[$], exp_w[$], exp_tile[$];
  logic [P*W-1:0] exp_data[$];
  int             read_cyc[$], acc_cyc[$], load_cyc[$];
  int             cyc = 0, done_cnt = 0, done_cyc = -1, cur_shift = 0;
  logic [W-1:0]   rd_x = '0;
  logic [P*W-1:0] rd_w = '0;
  logic [P*W-1:0] acc = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: observe at negedge, advance the SRAM/array model, drive pe_out after the edge.
  task automatic tick();
    logic [P*W-1:0] nacc;
    logic [W-1:0]   nx;
    logic [P*W-1:0] nw;
    logic [W-1:0]   pr;
    @(negedge clk);
    cyc++;
    check("rd_pair", 128'(w_rd), 128'(in_rd));
    check("pe_shift", 128'(pe_shift), busy ? 128'(cur_shift) : 128'(0));
    if (in_rd) begin
      read_cyc.push_back(cyc);
      if (exp_in.size() == 0) check("extra_read", 128'(1), 128'(0));
      else begin
        check("in_addr", 128'(in_addr), 128'(exp_in.pop_front()));
        check("w_addr", 128'(w_addr), 128'(exp_w.pop_front()));
      end
    end
    if (out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      if (exp_data.size() == 0) check("extra_out", 128'(1), 128'(0));
      else begin
        check("out_data", 128'(out_data), 128'(exp_data.pop_front()));
        check("out_tile", 128'(out_tile), 128'(exp_tile.pop_front()));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !pe_rst_n) load_cyc.push_back(cyc);
    for (int p = 0; p < P; p++) begin
      pr = 16'($signed(rd_x) * $signed(rd_w[p*W +: W]));
      nacc[p*W +: W] = (pe_rst_n ? acc[p*W +: W] : 16'd0) + pr;
    end
    nx = in_rd ? xmem[in_addr] : rd_x;
    nw = w_rd ? wmem[w_addr] : rd_w;
    @(posedge clk);
    #1;
    acc    = nacc;
    pe_out = nacc;
    rd_x   = nx;
    rd_w   = nw;
  endtask

  task automatic prep(input int L, input int T, input bit mode);
    logic [P*W-1:0] e;
    logic [W-1:0]   sum;
    for (int j = 0; j < L; j++) xmem[j] = mode ? 16'd1 : 16'($urandom_range(0, 15)) - 16'd8;
    for (int k = 0; k < L * T; k++)
      for (int p = 0; p < P; p++)
        wmem[k][p*W +: W] = mode ? ((p % 2 == 1) ? 16'd7 : 16'hFFFB)
                                 : 16'($urandom_range(0, 15)) - 16'd8;
    if (L > 0 && T > 0) begin
      for (int t = 0; t < T; t++) begin
        for (int j = 0; j < L; j++) begin
          exp_in.push_back(j);
          exp_w.push_back(t * L + j);
        end
        for (int p = 0; p < P; p++) begin
          sum = '0;
          for (int j = 0; j < L; j++)
            sum = sum + 16'($signed(xmem[j]) * $signed(wmem[t*L+j][p*W +: W]));
`ifdef FCL_RELU_EN
          if (sum[W-1]) sum = '0;
`endif
          e[p*W +: W] = sum;
        end
        exp_data.push_back(e);
        exp_tile.push_back(t);
      end
    end
    read_cyc.delete();
    acc_cyc.delete();
    load_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic run(input int L, input int T, input int sh, input bit stall, input bit mode);
    int s, rise, scnt, k;
    prep(L, T, mode);
    in_len = LW'(L);
    num_tiles = TW'(T);
    shift_cfg = SW'(sh);
    cur_shift = sh;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    in_len = LW'($urandom);
    num_tiles = TW'($urandom);
    shift_cfg = SW'($urandom);
    rise = -1;
    scnt = 0;
    k = 0;
    while (done_cnt == 0 && k < 800) begin
      if (stall && scnt < 20 && (scnt > 0 || out_valid)) begin
        out_ready = 1'b0;
        scnt++;
      end else begin
        if (stall && scnt == 20 && rise < 0) rise = cyc + 1;
        out_ready = 1'b1;
      end
      tick();
      k++;
    end
    out_ready = 1'b1;
    repeat (3) tick();
    check("done_cnt", 128'(done_cnt), 128'(1));
    check("busy_end", 128'(busy), 128'(0));
    check("reads_left", 128'(exp_in.size()), 128'(0));
    check("outs_left", 128'(exp_data.size()), 128'(0));
    if (L == 0 || T == 0) begin
      check("zero_done_cyc", 128'(done_cyc), 128'(s + 1));
      check("zero_reads", 128'(read_cyc.size()), 128'(0));
      check("zero_outs", 128'(acc_cyc.size()), 128'(0));
    end else begin
      check("first_read", 128'(read_cyc[0]), 128'(s + 1));
      check("first_load", 128'(load_cyc[0]), 128'(s + 2));
      check("n_loads", 128'(load_cyc.size()), 128'(T));
      if (!stall) begin
        for (int t = 0; t < T; t++) check("out_cyc", 128'(acc_cyc[t]), 128'(s + (t + 1) * (L + 3)));
        check("done_cyc", 128'(done_cyc), 128'(s + T * (L + 3)));
      end else begin
        check("stall_accept", 128'(acc_cyc[0]), 128'(rise));
        check("stall_restart", 128'(read_cyc[L]), 128'(rise + 1));
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rv_busy", 128'(busy), 128'(0));
    check("rv_done", 128'(done), 128'(0));
    check("rv_in_rd", 128'(in_rd), 128'(0));
    check("rv_w_rd", 128'(w_rd), 128'(0));
    check("rv_in_addr", 128'(in_addr), 128'(0));
    check("rv_w_addr", 128'(w_addr), 128'(0));
    check("rv_pe_rst_n", 128'(pe_rst_n), 128'(0));
    check("rv_pe_shift", 128'(pe_shift), 128'(0));
    check("rv_out_valid", 128'(out_valid), 128'(0));
    check("rv_out_data", 128'(out_data), 128'(0));
    check("rv_out_tile", 128'(out_tile), 128'(0));
  endtask

  task automatic reset_mid();
    int k;
    prep(3, 3, 1'b0);
    in_len = 10'd3;
    num_tiles = 8'd3;
    shift_cfg = 6'd5;
    cur_shift = 5;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (read_cyc.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    rst = 1'b0;
    tick();
    check_reset_vals();
    rst = 1'b1;
    exp_in.delete();
    exp_w.delete();
    exp_data.delete();
    exp_tile.delete();
    repeat (6) tick();
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b1;
    tick();
    run(4, 1, 0, 1'b0, 1'b0);
    run(3, 3, 2, 1'b0, 1'b0);
    run(3, 3, 1, 1'b1, 1'b0);
    run(0, 2, 0, 1'b0, 1'b0);
    run(2, 0, 0, 1'b0, 1'b0);
    run(1, 2, 3, 1'b0, 1'b0);
    run(1, 1, 0, 1'b0, 1'b1);
    reset_mid();
    run(3, 3, 4, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      run($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 63), 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
